aes_spi_master: RTL and testbench

- Host-side SPI master that feeds the AES SPI slave/encryption stage.
- Latches one 128-bit plaintext block and one 32*Nk-bit key from the host, then serialises them MSB-first on SDI.
- After a configurable gap in which SCLK keeps running, it clocks in the 128-bit ciphertext from SDO and presents it in parallel with a one-cycle done pulse.
- Sits directly upstream of the slave, as its only SPI driver.

---
 rtl/aes_spi_master_if.sv | 26 ++
 rtl/aes_spi_master.sv | 147 ++++++++++++++
 tb/tb_aes_spi_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_master_if.sv
// Host-side bundle for aes_spi_master: parallel host handshake plus the SPI pins.
// The master modport is the DUT view; the slave modport is the host/SPI-peer view.
interface aes_spi_master_if #(
    parameter int unsigned Nk = 4
);
    logic                start;
    logic [127:0]        data_in;
    logic [32*Nk-1:0]    key_in;
    logic                busy;
    logic                done;
    logic [127:0]        data_out;
    logic                SCLK;
    logic                CS;
    logic                SDI;
    logic                SDO;

    modport master (
        input  start, data_in, key_in, SDO,
        output busy, done, data_out, SCLK, CS, SDI
    );

    modport slave (
        output start, data_in, key_in, SDO,
        input  busy, done, data_out, SCLK, CS, SDI
    );
endinterface

// File: rtl/aes_spi_master.sv
// SPI master feeding the AES slave: sends plaintext+key MSB-first, idles GAP_BITS
// SCLK periods, then shifts in the 128-bit ciphertext and reports it with a done pulse.
module aes_spi_master #(
    parameter int unsigned Nk       = 4,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned GAP_BITS = 8
) (
    input logic                clk,
    input logic                rst,
    aes_spi_master_if.master   bus
);
    localparam int unsigned TX    = 128 + 32 * Nk;
    localparam int unsigned TOTAL = TX + GAP_BITS + 128;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] TxEnd    = CW'(TX);
    localparam logic [CW-1:0] GapEnd   = CW'(TX + GAP_BITS);
    localparam logic [CW-1:0] FrameEnd = CW'(TOTAL);
    localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StSend, StGap, StRecv, StFin} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [TX-1:0]   tx_sr_q, tx_sr_d;
    logic [127:0]    rx_sr_q, rx_sr_d;
    logic [127:0]    data_out_q, data_out_d;
    logic            sclk_q, sclk_d;
    logic            cs_q, cs_d;
    logic            sdi_q, sdi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            active, tick, rise, fall;
    logic [CW-1:0]   bit_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            sdi_q      <= sdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // SCLK edges are decided one clk ahead: rise/fall mark the clk edge that toggles SCLK.
    assign active  = (state_q == StSend) || (state_q == StGap) || (state_q == StRecv);
    assign tick    = (div_q == DivLast);
    assign rise    = active && tick && !sclk_q;
    assign fall    = active && tick && sclk_q;
    assign bit_nxt = bit_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        sdi_d      = sdi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (active) begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) sclk_d = !sclk_q;
            if (fall) bit_d = bit_nxt;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    tx_sr_d = {bus.data_in, bus.key_in};
                    sdi_d   = bus.data_in[127];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (fall) begin
                    tx_sr_d = tx_sr_q << 1;
                    if (bit_nxt == TxEnd) begin
                        sdi_d   = 1'b0;
                        state_d = StGap;
                    end else begin
                        sdi_d = tx_sr_q[TX-2];
                    end
                end
            end
            StGap: begin
                if (fall && bit_nxt == GapEnd) state_d = StRecv;
            end
            StRecv: begin
                if (rise) rx_sr_d = {rx_sr_q[126:0], bus.SDO};
                // Closing the frame on the last falling edge makes the done cycle the FIN cycle.
                if (fall && bit_nxt == FrameEnd) begin
                    cs_d       = 1'b1;
                    sclk_d     = 1'b0;
                    data_out_d = rx_sr_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StFin;
                end
            end
            StFin: begin
                div_d   = '0;
                bit_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.SCLK     = sclk_q;
    assign bus.CS       = cs_q;
    assign bus.SDI      = sdi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master (Nk=4 and Nk=8 instances) with a behavioural
// SPI slave that answers FIPS-197 known-answer frames.
module tb_aes_spi_master;
    localparam int unsigned ClkDiv  = 2;
    localparam int unsigned GapBits = 8;

    localparam logic [127:0] Pt     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] Key256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] Ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] Pt2    = 128'hfedcba98765432100123456789abcdef;
    localparam logic [255:0] Key2   =
        256'hcafef00d00000000111111112222222233333333444444445555555566666666;
    localparam logic [127:0] Mask   = 128'hffff0000ffff0000ffff0000ffff0000;
    localparam logic [127:0] Ct2    = 128'h0123ba9889ab3210fedc45677654cdef;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_spi_master_if #(.Nk(4)) b4 ();
    aes_spi_master_if #(.Nk(8)) b8 ();

    aes_spi_master #(.Nk(4), .CLK_DIV(ClkDiv), .GAP_BITS(GapBits)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    aes_spi_master #(.Nk(8), .CLK_DIV(ClkDiv), .GAP_BITS(GapBits)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    logic sclk_s [2];
    logic cs_s   [2];
    logic sdi_s  [2];
    logic done_s [2];
    logic sdo_s  [2];

    assign sclk_s[0] = b4.SCLK;
    assign sclk_s[1] = b8.SCLK;
    assign cs_s[0]   = b4.CS;
    assign cs_s[1]   = b8.CS;
    assign sdi_s[0]  = b4.SDI;
    assign sdi_s[1]  = b8.SDI;
    assign done_s[0] = b4.done;
    assign done_s[1] = b8.done;
    assign b4.SDO    = sdo_s[0];
    assign b8.SDO    = sdo_s[1];

    logic         sclk_p  [2];
    logic         cs_p    [2];
    logic         gap_err [2];
    logic [383:0] cap     [2];
    logic [127:0] resp    [2];
    int           rise_cnt [2];
    int           fall_cnt [2];
    int           cs_low   [2];
    int           done_cnt [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int tx_len(input int i);
        return (i == 0) ? 256 : 384;
    endfunction

    // Slave's answer: known ciphertext for the FIPS-197 frames, a fixed mask otherwise.
    function automatic logic [127:0] model_ct(input int i, input logic [383:0] c);
        if (i == 0 && c[383:256] == Pt && c[255:128] == Key256[255:128]) return Ct128;
        if (i == 1 && c[383:256] == Pt && c[255:0] == Key256) return Ct256;
        return c[383:256] ^ Mask;
    endfunction

    // Slave model: captures SDI on SCLK rises, drives SDO after SCLK falls.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sclk_p[i] <= sclk_s[i];
            cs_p[i]   <= cs_s[i];
            if (!rst) begin
                rise_cnt[i] <= 0;
                fall_cnt[i] <= 0;
                cs_low[i]   <= 0;
                gap_err[i]  <= 1'b0;
                sdo_s[i]    <= 1'b0;
                resp[i]     <= '0;
                cap[i]      <= '0;
            end else begin
                if (done_s[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (cs_p[i] && !cs_s[i]) begin
                    rise_cnt[i] <= 0;
                    fall_cnt[i] <= 0;
                    cs_low[i]   <= 1;
                    gap_err[i]  <= 1'b0;
                end else begin
                    if (!cs_s[i]) cs_low[i] <= cs_low[i] + 1;
                    if (!cs_s[i] && sclk_s[i] && !sclk_p[i]) begin
                        if (rise_cnt[i] < tx_len(i)) cap[i][383 - rise_cnt[i]] <= sdi_s[i];
                        else if (rise_cnt[i] < tx_len(i) + GapBits && sdi_s[i]) gap_err[i] <= 1'b1;
                        rise_cnt[i] <= rise_cnt[i] + 1;
                    end
                    if (!sclk_s[i] && sclk_p[i]) begin
                        fall_cnt[i] <= fall_cnt[i] + 1;
                        if (fall_cnt[i] + 1 == tx_len(i)) resp[i] <= model_ct(i, cap[i]);
                        if (fall_cnt[i] + 1 >= tx_len(i) + GapBits &&
                            fall_cnt[i] + 1 < tx_len(i) + GapBits + 128)
                            sdo_s[i] <= resp[i][127 - (fall_cnt[i] + 1 - tx_len(i) - GapBits)];
                        else
                            sdo_s[i] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i, input logic [127:0] pt, input logic [255:0] key);
        if (i == 0) begin
            b4.start = 1'b1; b4.data_in = pt; b4.key_in = key[255:128];
        end else begin
            b8.start = 1'b1; b8.data_in = pt; b8.key_in = key;
        end
        step();
        b4.start = 1'b0;
        b8.start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int cyc;
        cyc = 0;
        while (!done_s[i] && cyc < budget) begin
            step();
            cyc++;
        end
        if (!done_s[i]) check_eq("done_timeout", 0, 1);
    endtask

    int d0;

    initial begin
        b4.start = 1'b0; b4.data_in = '0; b4.key_in = '0;
        b8.start = 1'b0; b8.data_in = '0; b8.key_in = '0;
        rst = 1'b0;
        repeat (5) step();
        check_eq("rst_cs",       b4.CS, 1);
        check_eq("rst_sclk",     b4.SCLK, 0);
        check_eq("rst_sdi",      b4.SDI, 0);
        check_eq("rst_busy",     b4.busy, 0);
        check_eq("rst_done",     b4.done, 0);
        check_eq("rst_data_out", b4.data_out, 0);
        check_eq("rst_cs8",      b8.CS, 1);
        check_eq("rst_dout8",    b8.data_out, 0);
        rst = 1'b1;
        step();

        // Known-answer transfer, Nk=4
        d0 = done_cnt[0];
        pulse_start(0, Pt, Key256);
        check_eq("kat_busy", b4.busy, 1);
        wait_done(0, 4000);
        check_eq("kat_data_out", b4.data_out, Ct128);
        check_eq("kat_cs_low",   cs_low[0], 1568);
        check_eq("kat_rises",    rise_cnt[0], 392);
        check_eq("kat_ser_pt",   cap[0][383:256], Pt);
        check_eq("kat_ser_key",  cap[0][255:128], Key256[255:128]);
        check_eq("kat_gap_sdi",  gap_err[0], 0);
        check_eq("kat_cs_end",   b4.CS, 1);
        check_eq("kat_busy_end", b4.busy, 0);
        step();
        check_eq("kat_done_1cyc", b4.done, 0);
        check_eq("kat_hold",      b4.data_out, Ct128);
        repeat (5) step();
        check_eq("kat_done_cnt", done_cnt[0] - d0, 1);

        // Busy lockout: second start and changed inputs mid-frame
        d0 = done_cnt[0];
        pulse_start(0, Pt, Key256);
        repeat (98) step();
        b4.start = 1'b1; b4.data_in = ~Pt; b4.key_in = '0;
        step();
        b4.start = 1'b0;
        wait_done(0, 4000);
        check_eq("lock_cs_low",   cs_low[0], 1568);
        check_eq("lock_rises",    rise_cnt[0], 392);
        check_eq("lock_ser_pt",   cap[0][383:256], Pt);
        check_eq("lock_data_out", b4.data_out, Ct128);
        repeat (5) step();
        check_eq("lock_done_cnt", done_cnt[0] - d0, 1);
        check_eq("lock_no_restart", b4.CS, 1);

        // Mid-transfer reset
        d0 = done_cnt[0];
        pulse_start(0, Pt, Key256);
        repeat (699) step();
        rst = 1'b0;
        #1;
        check_eq("mrst_cs",   b4.CS, 1);
        check_eq("mrst_sclk", b4.SCLK, 0);
        check_eq("mrst_dout", b4.data_out, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (20) step();
        check_eq("mrst_no_done", done_cnt[0] - d0, 0);
        check_eq("mrst_idle_cs", b4.CS, 1);
        pulse_start(0, Pt, Key256);
        wait_done(0, 4000);
        check_eq("mrst_retry_dout",   b4.data_out, Ct128);
        check_eq("mrst_retry_cs_low", cs_low[0], 1568);

        // Nk=8 back-to-back
        pulse_start(1, Pt, Key256);
        wait_done(1, 6000);
        check_eq("nk8_a_dout",   b8.data_out, Ct256);
        check_eq("nk8_a_rises",  rise_cnt[1], 520);
        check_eq("nk8_a_cs_low", cs_low[1], 2080);
        check_eq("nk8_a_ser",    cap[1], {Pt, Key256});
        check_eq("nk8_a_gap",    gap_err[1], 0);
        b8.start = 1'b1; b8.data_in = Pt2; b8.key_in = Key2;
        step();
        check_eq("nk8_fin_ignore", b8.CS, 1);
        step();
        b8.start = 1'b0;
        check_eq("nk8_b_started", b8.CS, 0);
        repeat (1000) step();
        check_eq("nk8_hold_mid", b8.data_out, Ct256);
        wait_done(1, 6000);
        check_eq("nk8_b_dout",   b8.data_out, Ct2);
        check_eq("nk8_b_rises",  rise_cnt[1], 520);
        check_eq("nk8_b_cs_low", cs_low[1], 2080);
        check_eq("nk8_b_ser",    cap[1], {Pt2, Key2});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
